// File: rtl/mastermind_round_ctrl.sv
// Mastermind round sequencer: captures the secret, edge-detects the buttons, runs one
// grade handshake per guess and turns black/white counts into peg-feedback digits.
module mastermind_round_ctrl #(
  parameter int unsigned MAX_ROUNDS = 10
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        start_game_i,
  input  logic        grade_it_i,
  input  logic [11:0] guess_i,
  input  logic [11:0] secret_i,
  output logic        grade_req_o,
  output logic [11:0] grade_guess_o,
  output logic [11:0] grade_secret_o,
  input  logic        grade_ack_i,
  input  logic [2:0]  grade_black_i,
  input  logic [2:0]  grade_white_i,
  output logic [2:0]  feedback0_o,
  output logic [2:0]  feedback1_o,
  output logic [2:0]  feedback2_o,
  output logic [2:0]  feedback3_o,
  output logic [3:0]  round_number_o,
  output logic        won_o,
  output logic        lost_o,
  output logic        bad_guess_o
);

  localparam int unsigned PEG_W  = 3;
  localparam int unsigned NPEGS  = 4;
  localparam int unsigned CODE_W = PEG_W * NPEGS;
  localparam int unsigned RND_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_REQ,
    S_CHECK,
    S_WON,
    S_LOST
  } state_e;

  state_e              state_q, state_d;
  logic                start_q, grade_q;
  logic                req_q, req_d;
  logic [CODE_W-1:0]   guess_q, guess_d;
  logic [CODE_W-1:0]   secret_q, secret_d;
  logic [CODE_W-1:0]   fb_q, fb_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic                won_q, won_d;
  logic                lost_q, lost_d;
  logic                bad_q, bad_d;
  logic [PEG_W-1:0]    black_q, black_d;
  logic [PEG_W-1:0]    white_q, white_d;

  logic                start_edge_c;
  logic                grade_edge_c;
  logic                guess_bad_c;
  logic [PEG_W-1:0]    black_sat_c;
  logic [PEG_W-1:0]    white_sat_c;
  logic [RND_W-1:0]    pair_sum_c;
  logic [CODE_W-1:0]   fb_fill_c;

  assign start_edge_c = start_game_i & ~start_q;
  assign grade_edge_c = grade_it_i & ~grade_q;

  // A peg of 6 or 7 has both upper bits set.
  always_comb begin
    guess_bad_c = 1'b0;
    for (int i = 0; i < int'(NPEGS); i++) begin
      if (guess_i[i*PEG_W+1 +: 2] == 2'b11) guess_bad_c = 1'b1;
    end
  end

  // A faulty grader reporting black + white > 4 loses the surplus whites.
  always_comb begin
    black_sat_c = (black_q > 3'd4) ? 3'd4 : black_q;
    pair_sum_c  = {1'b0, black_sat_c} + {1'b0, white_q};
    white_sat_c = (pair_sum_c > 4'd4) ? 3'(3'd4 - black_sat_c) : white_q;
  end

  // Slots fill from feedback3 down: blacks as 2, then whites as 1, rest 0.
  always_comb begin
    fb_fill_c = '0;
    for (int i = 0; i < int'(NPEGS); i++) begin
      if (4'(NPEGS - 1 - i) < {1'b0, black_sat_c}) begin
        fb_fill_c[i*PEG_W +: PEG_W] = 3'd2;
      end else if (4'(NPEGS - 1 - i) < ({1'b0, black_sat_c} + {1'b0, white_sat_c})) begin
        fb_fill_c[i*PEG_W +: PEG_W] = 3'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    guess_d  = guess_q;
    secret_d = secret_q;
    fb_d     = fb_q;
    round_d  = round_q;
    won_d    = won_q;
    lost_d   = lost_q;
    bad_d    = 1'b0;
    black_d  = black_q;
    white_d  = white_q;

    if (start_edge_c) begin
      secret_d = secret_i;
      round_d  = RND_W'(1);
      fb_d     = '0;
      won_d    = 1'b0;
      lost_d   = 1'b0;
      req_d    = 1'b0;
      state_d  = S_PLAY;
    end else begin
      unique case (state_q)
        S_PLAY: begin
          if (grade_edge_c) begin
            if (guess_bad_c) begin
              bad_d = 1'b1;
            end else begin
              guess_d = guess_i;
              req_d   = 1'b1;
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (grade_ack_i) begin
            black_d = grade_black_i;
            white_d = grade_white_i;
            req_d   = 1'b0;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          fb_d = fb_fill_c;
          if (black_sat_c == 3'd4) begin
            won_d   = 1'b1;
            state_d = S_WON;
          end else if (round_q == RND_W'(MAX_ROUNDS)) begin
            lost_d  = 1'b1;
            state_d = S_LOST;
          end else begin
            round_d = round_q + RND_W'(1);
            state_d = S_PLAY;
          end
        end
        S_IDLE, S_WON, S_LOST: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      grade_q  <= 1'b0;
      req_q    <= 1'b0;
      guess_q  <= '0;
      secret_q <= '0;
      fb_q     <= '0;
      round_q  <= '0;
      won_q    <= 1'b0;
      lost_q   <= 1'b0;
      bad_q    <= 1'b0;
      black_q  <= '0;
      white_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_game_i;
      grade_q  <= grade_it_i;
      req_q    <= req_d;
      guess_q  <= guess_d;
      secret_q <= secret_d;
      fb_q     <= fb_d;
      round_q  <= round_d;
      won_q    <= won_d;
      lost_q   <= lost_d;
      bad_q    <= bad_d;
      black_q  <= black_d;
      white_q  <= white_d;
    end
  end

  assign grade_req_o    = req_q;
  assign grade_guess_o  = guess_q;
  assign grade_secret_o = secret_q;
  assign feedback0_o    = fb_q[0*PEG_W +: PEG_W];
  assign feedback1_o    = fb_q[1*PEG_W +: PEG_W];
  assign feedback2_o    = fb_q[2*PEG_W +: PEG_W];
  assign feedback3_o    = fb_q[3*PEG_W +: PEG_W];
  assign round_number_o = round_q;
  assign won_o          = won_q;
  assign lost_o         = lost_q;
  assign bad_guess_o    = bad_q;

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Directed bench for mastermind_round_ctrl with hand-computed expectations.
module tb_mastermind_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_game, grade_it, ack;
  logic [11:0] guess, secret;
  logic [2:0]  black, white;
  logic        req;
  logic [11:0] g_guess, g_secret;
  logic [2:0]  fb0, fb1, fb2, fb3;
  logic [3:0]  round_n;
  logic        won, lost, bad;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  always #5 clk = ~clk;

  mastermind_round_ctrl #(.MAX_ROUNDS(10)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .start_game_i(start_game), .grade_it_i(grade_it),
    .guess_i(guess), .secret_i(secret),
    .grade_req_o(req), .grade_guess_o(g_guess), .grade_secret_o(g_secret),
    .grade_ack_i(ack), .grade_black_i(black), .grade_white_i(white),
    .feedback0_o(fb0), .feedback1_o(fb1), .feedback2_o(fb2), .feedback3_o(fb3),
    .round_number_o(round_n), .won_o(won), .lost_o(lost), .bad_guess_o(bad)
  );

  wire [11:0] fb_all = {fb3, fb2, fb1, fb0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 'o%0o expected 'o%0o", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [11:0] s);
    secret = s; start_game = 1'b1;
    step();
    start_game = 1'b0;
  endtask

  // Press, same-cycle ack, then the CHECK cycle.
  task automatic do_grade(input logic [11:0] g, input logic [2:0] b, input logic [2:0] w);
    guess = g; grade_it = 1'b1;
    step();
    grade_it = 1'b0; ack = 1'b1; black = b; white = w;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(req), 32'd0);
    check({tag, "_guess"}, 32'(g_guess), 32'd0);
    check({tag, "_secret"}, 32'(g_secret), 32'd0);
    check({tag, "_fb"}, 32'(fb_all), 32'd0);
    check({tag, "_round"}, 32'(round_n), 32'd0);
    check({tag, "_wonlostbad"}, 32'({won, lost, bad}), 32'd0);
  endtask

  initial begin
    int cnt, pulses;
    logic prev;
    rst_n = 1'b0; start_game = 1'b0; grade_it = 1'b0; ack = 1'b0;
    guess = '0; secret = '0; black = '0; white = '0;
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Win in round 1; start stays high throughout to prove single edge.
    secret = 12'o0123; start_game = 1'b1;
    step();
    check("start_round", 32'(round_n), 32'd1);
    check("start_secret", 32'(g_secret), 32'o0123);
    guess = 12'o0123; grade_it = 1'b1;
    step();
    grade_it = 1'b0;
    check("win_req", 32'(req), 32'd1);
    check("win_guess", 32'(g_guess), 32'o0123);
    step();
    check("win_req_wait", 32'(req), 32'd1);
    ack = 1'b1; black = 3'd4; white = 3'd0;
    step();
    ack = 1'b0;
    check("win_req_drop", 32'(req), 32'd0);
    step();
    check("win_won", 32'(won), 32'd1);
    check("win_fb", 32'(fb_all), 32'o2222);
    check("win_round", 32'(round_n), 32'd1);
    start_game = 1'b0;
    step();

    // Ten non-winning rounds ending in loss.
    pulse_start(12'o5432);
    check("g2_secret", 32'(g_secret), 32'o5432);
    do_grade(12'o0000, 3'd0, 3'd0);
    check("r1_round", 32'(round_n), 32'd2);
    do_grade(12'o0011, 3'd0, 3'd1);
    check("r2_fb", 32'(fb_all), 32'o1000);
    do_grade(12'o0012, 3'd1, 3'd2);
    check("r3_fb", 32'(fb_all), 32'o2110);
    check("r3_round", 32'(round_n), 32'd4);
    check("r3_wonlost", 32'({won, lost}), 32'd0);
    do_grade(12'o0013, 3'd3, 3'd3);
    check("sat_fb", 32'(fb_all), 32'o2221);
    do_grade(12'o0014, 3'd2, 3'd2);
    check("r5_fb", 32'(fb_all), 32'o2211);
    check("r5_round", 32'(round_n), 32'd6);
    for (int r = 6; r < 10; r++) do_grade(12'o0100, 3'd0, 3'd0);
    check("r9_round", 32'(round_n), 32'd10);
    check("r9_lost", 32'(lost), 32'd0);
    do_grade(12'o0200, 3'd1, 3'd0);
    check("lost", 32'(lost), 32'd1);
    check("lost_round", 32'(round_n), 32'd10);
    check("lost_fb", 32'(fb_all), 32'o2000);
    grade_it = 1'b1;
    step();
    check("after_lost_req", 32'(req), 32'd0);
    grade_it = 1'b0;
    step();
    check("after_lost_req2", 32'(req), 32'd0);

    // Held grade button with an 8-cycle request.
    pulse_start(12'o1111);
    guess = 12'o1234; grade_it = 1'b1;
    cnt = 0; pulses = 0; prev = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (req) cnt++;
      if (req && !prev) pulses++;
      prev = req;
      if (i == 3) guess = 12'o5555;
      if (i == 5) check("hold_guess_stable", 32'(g_guess), 32'o1234);
      ack = (cnt == 8 && req);
      black = 3'd1; white = 3'd1;
    end
    ack = 1'b0; grade_it = 1'b0;
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_cycles", 32'(cnt), 32'd8);
    check("hold_fb", 32'(fb_all), 32'o2100);
    check("hold_round", 32'(round_n), 32'd2);
    step();

    // Illegal peg2 = 7.
    guess = 12'o0712; grade_it = 1'b1;
    step();
    check("bad_pulse", 32'(bad), 32'd1);
    check("bad_req", 32'(req), 32'd0);
    grade_it = 1'b0;
    step();
    check("bad_end", 32'(bad), 32'd0);
    check("bad_round", 32'(round_n), 32'd2);
    check("bad_fb", 32'(fb_all), 32'o2100);
    check("bad_req2", 32'(req), 32'd0);

    // Start coinciding with ack discards the result.
    guess = 12'o0000; grade_it = 1'b1;
    step();
    grade_it = 1'b0;
    check("race_req", 32'(req), 32'd1);
    ack = 1'b1; black = 3'd4; white = 3'd0; start_game = 1'b1; secret = 12'o0044;
    step();
    ack = 1'b0; start_game = 1'b0;
    check("race_round", 32'(round_n), 32'd1);
    check("race_fb", 32'(fb_all), 32'd0);
    check("race_req0", 32'(req), 32'd0);
    step();
    check("race_won", 32'(won), 32'd0);
    check("race_round2", 32'(round_n), 32'd1);

    // Asynchronous reset mid-request.
    guess = 12'o0123; grade_it = 1'b1;
    step();
    grade_it = 1'b0;
    check("rq_req", 32'(req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async");
    #10 rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
